sort_ctrl: RTL and testbench

//  Sequencer and arbiter for the single-port sorter memory (SIZE words x DATA_W bits).

---
 rtl/sort_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sort_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_ctrl.sv
// rtl/sort_ctrl.sv - in-place bubble-sort sequencer and host arbiter for a single-port sorter memory
//
// Purpose:
//   While idle, the host port passes straight through to the sorter memory.
//   A start pulse hands the memory to an internal sequencer. The sequencer
//   bubble-sorts the words into unsigned ascending order, stopping early
//   after a pass that makes no swap. It then pulses done and returns the
//   memory to the host.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              one-cycle pulse, sampled only in IDLE
//   busy               high from the cycle after start is accepted through DONE
//   done               one-cycle completion pulse
//   host_addr/wdata    host word address and write data (IDLE only)
//   host_we/host_re    host write/read request (exactly one must be set for an access)
//   host_rdata         host read data; zero unless an IDLE host read is in progress
//   mem_addr/wdata     memory address and write data
//   mem_we/mem_re      memory write/read strobes (never both set)
//   mem_en             memory enable, active low
//   mem_rdata          combinational memory read data

module sort_ctrl #(
    parameter int SIZE   = 8,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(SIZE) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [AW-1:0]     host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_we,
    input  logic              host_re,
    output logic [DATA_W-1:0] host_rdata,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        CMP  = 3'd3,
        WR_A = 3'd4,
        WR_B = 3'd5,
        PASS = 3'd6,
        DONE = 3'd7
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(SIZE - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_t            state, nxt;
    logic [AW-1:0]     i, j;
    logic              swapped;
    logic [DATA_W-1:0] a, b;

    logic              host_acc;
    logic              last_pair;
    logic              a_gt_b;

    // A host access needs exactly one of we/re. rst_n is included so that
    // mem_en goes inactive as soon as reset asserts, even if the host holds
    // a request.
    assign host_acc  = rst_n && (state == IDLE) && (host_we ^ host_re);
    assign last_pair = (j == (i - ONE));
    assign a_gt_b    = (a > b);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Gated to a real read access, so a floating bus never reaches the host.
    assign host_rdata = (host_acc && host_re) ? mem_rdata : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next state
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start) nxt = (SIZE == 1) ? DONE : RD_A;
            RD_A: nxt = RD_B;
            RD_B: nxt = CMP;
            CMP: begin
                if (a_gt_b)         nxt = WR_A;
                else if (last_pair) nxt = PASS;
                else                nxt = RD_A;
            end
            WR_A: nxt = WR_B;
            WR_B: nxt = last_pair ? PASS : RD_A;
            PASS: nxt = (!swapped || i == ONE) ? DONE : RD_A;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Memory port decode. Outside IDLE it depends only on registered
    // state, j, a and b, so the outputs are stable for the whole cycle.
    always_comb begin
        mem_en    = 1'b1;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (host_acc) begin
                    mem_en    = 1'b0;
                    mem_addr  = host_addr;
                    mem_wdata = host_wdata;
                    mem_we    = host_we;
                    mem_re    = host_re;
                end
            end
            RD_A: begin
                mem_en   = 1'b0;
                mem_re   = 1'b1;
                mem_addr = j;
            end
            RD_B: begin
                mem_en   = 1'b0;
                mem_re   = 1'b1;
                mem_addr = j + ONE;
            end
            WR_A: begin
                mem_en    = 1'b0;
                mem_we    = 1'b1;
                mem_addr  = j;
                mem_wdata = b;
            end
            WR_B: begin
                mem_en    = 1'b0;
                mem_we    = 1'b1;
                mem_addr  = j + ONE;
                mem_wdata = a;
            end
            default: ;
        endcase
    end

    // Pass/pair counters and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i       <= LAST;
            j       <= '0;
            swapped <= 1'b0;
            a       <= '0;
            b       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i       <= LAST;
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                RD_A: a <= mem_rdata;
                RD_B: b <= mem_rdata;
                CMP: begin
                    if (!a_gt_b && !last_pair) j <= j + ONE;
                end
                WR_B: begin
                    swapped <= 1'b1;
                    if (!last_pair) j <= j + ONE;
                end
                PASS: begin
                    if (swapped && i != ONE) begin
                        i       <= i - ONE;
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_ctrl.sv
// tb/tb_sort_ctrl.sv - scoreboard bench for sort_ctrl (SIZE=8 and SIZE=1 instances)

module tb_sort_ctrl;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int AW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_we, host_re;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we, mem_re, mem_en;
    wire  [DW-1:0] mem_rdata;

    logic          start1;
    logic          busy1, done1;
    logic [0:0]    host_addr1;
    logic [DW-1:0] host_wdata1;
    logic          host_we1, host_re1;
    logic [DW-1:0] host_rdata1;
    logic [0:0]    mem_addr1;
    logic [DW-1:0] mem_wdata1;
    logic          mem_we1, mem_re1, mem_en1;
    wire  [DW-1:0] mem_rdata1;

    always #5 clk = ~clk;

    sort_ctrl #(.SIZE(N), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we),
        .host_re(host_re), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_en(mem_en), .mem_rdata(mem_rdata)
    );

    sort_ctrl #(.SIZE(1), .DATA_W(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .host_addr(host_addr1), .host_wdata(host_wdata1), .host_we(host_we1),
        .host_re(host_re1), .host_rdata(host_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .mem_re(mem_re1), .mem_en(mem_en1), .mem_rdata(mem_rdata1)
    );

    // Memory models: combinational read, synchronous write
    logic [DW-1:0] mem [0:N-1];
    logic [DW-1:0] mem1;
    assign mem_rdata  = (!mem_en && mem_re) ? mem[mem_addr[2:0]] : 'z;
    assign mem_rdata1 = (!mem_en1 && mem_re1) ? mem1 : 'z;

    always @(posedge clk) begin
        if (!mem_en && mem_we) mem[mem_addr[2:0]] <= mem_wdata;
        if (!mem_en1 && mem_we1) mem1 <= mem_wdata1;
    end

    // Activity monitors
    int we_busy_cnt = 0;
    int done_cnt    = 0;
    int both_cnt    = 0;
    int acc1_cnt    = 0;
    always @(negedge clk) begin
        if (busy && mem_we)  we_busy_cnt++;
        if (done)            done_cnt++;
        if (mem_we && mem_re) both_cnt++;
        if (!mem_en1)        acc1_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] load_v [N];
    logic [DW-1:0] exp_v  [N];
    logic [DW-1:0] sb [$];

    // Independent reference: insertion sort of the loaded values
    task automatic build_expected();
        logic [DW-1:0] t;
        for (int k = 0; k < N; k++) exp_v[k] = load_v[k];
        for (int k = 1; k < N; k++) begin
            for (int m = k; m > 0; m--) begin
                if (exp_v[m-1] > exp_v[m]) begin
                    t = exp_v[m]; exp_v[m] = exp_v[m-1]; exp_v[m-1] = t;
                end
            end
        end
    endtask

    task automatic host_load();
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            host_we = 1'b1; host_addr = AW'(k); host_wdata = load_v[k];
        end
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_readback(input string tag);
        logic [DW-1:0] e;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            host_re = 1'b1; host_addr = AW'(k);
            sb.push_back(exp_v[k]);
            #2;
            e = sb.pop_front();
            check($sformatf("%s_rd%0d", tag, k), host_rdata, e);
        end
        @(negedge clk);
        host_re = 1'b0;
    endtask

    // Starts a sort and counts cycles; cycle 1 is the first cycle after start is sampled
    task automatic run_sort(input string tag, input int exp_cyc, input bit inject, input int abort_at);
        int cyc;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        seen = 1'b0;
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        while (cyc < 2000) begin
            if (abort_at == cyc) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_en"}, 32'(mem_en), 32'd1);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (inject && cyc == 5) begin
                start = 1'b1; host_we = 1'b1; host_addr = '0; host_wdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            start = 1'b0; host_we = 1'b0;
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_cyc > 0) check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_after"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dc;
        rst_n = 1'b0; start = 1'b0;
        host_addr = '0; host_wdata = '0; host_we = 1'b0; host_re = 1'b0;
        start1 = 1'b0; host_addr1 = '0; host_wdata1 = '0; host_we1 = 1'b0; host_re1 = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_en", 32'(mem_en), 32'd1);
        check("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", host_rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Host both we and re: no access
        @(negedge clk);
        host_we = 1'b1; host_re = 1'b1;
        #2;
        check("both_en", 32'(mem_en), 32'd1);
        check("both_rdata", host_rdata, 32'd0);
        @(negedge clk);
        host_we = 1'b0; host_re = 1'b0;

        // T1: already sorted
        for (int k = 0; k < N; k++) load_v[k] = 32'(k + 1);
        build_expected();
        host_load();
        host_readback("t1pre");
        we_busy_cnt = 0;
        run_sort("t1", 23, 1'b0, 0);
        check("t1_no_we", 32'(we_busy_cnt), 32'd0);
        host_readback("t1");

        // T2: reversed
        for (int k = 0; k < N; k++) load_v[k] = 32'(N - k);
        build_expected();
        host_load();
        run_sort("t2", 148, 1'b0, 0);
        host_readback("t2");

        // T3: duplicates and extreme values
        load_v = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd3, 32'd1, 32'd2};
        build_expected();
        host_load();
        run_sort("t3", 0, 1'b0, 0);
        host_readback("t3");

        // T4: start and host write injected while busy
        for (int k = 0; k < N; k++) load_v[k] = 32'(N - k);
        build_expected();
        host_load();
        run_sort("t4", 148, 1'b1, 0);
        host_readback("t4");

        // T5: reset mid-sort, then a fresh sort
        host_load();
        dc = done_cnt;
        run_sort("t5", 0, 1'b0, 40);
        check("t5_no_done", 32'(done_cnt), 32'(dc));
        run_sort("t5b", 0, 1'b0, 0);
        host_readback("t5");

        check("we_re_never_both", 32'(both_cnt), 32'd0);

        // T6: SIZE=1
        acc1_cnt = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("t6_done_c1", 32'(done1), 32'd1);
        check("t6_busy_c1", 32'(busy1), 32'd1);
        @(negedge clk);
        check("t6_done_c2", 32'(done1), 32'd0);
        check("t6_busy_c2", 32'(busy1), 32'd0);
        check("t6_no_access", 32'(acc1_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
